wasm_mem_access_unit: RTL and testbench

- Byte-addressed WebAssembly load/store front end.
- Sits directly upstream of the word-wide linear-memory block and is the only master of that block's addr/re/we/wr_data port.
- Takes i32 load/store requests (base + static offset, 1/2/4 bytes, signed/unsigned) from the execute stage.
- Performs bounds checking, splits unaligned accesses that cross a word into two word accesses, and does read-modify-write for partial or spanning stores.
- Returns load data or a trap flag.

---
 rtl/wasm_mem_access_unit_if.sv | 37 +++
 rtl/wasm_mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_wasm_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wasm_mem_access_unit_if.sv
// Request/response and linear-memory port bundle for the wasm memory access unit.
// The unit takes the slave view; the execute stage plus memory environment takes the master view.
interface wasm_mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [31:0]           req_base;
  logic [31:0]           req_offset;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_trap;
  logic [31:0]           mem_addr;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_data_vld;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport master (
    output req_valid, req_store, req_size, req_signed, req_base, req_offset, req_wdata,
    output mem_rd_data, mem_rd_data_vld,
    input  req_ready, resp_valid, resp_rdata, resp_trap,
    input  mem_addr, mem_re, mem_we, mem_wr_data
  );

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_base, req_offset, req_wdata,
    input  mem_rd_data, mem_rd_data_vld,
    output req_ready, resp_valid, resp_rdata, resp_trap,
    output mem_addr, mem_re, mem_we, mem_wr_data
  );
endinterface

// File: rtl/wasm_mem_access_unit.sv
// Byte-addressed wasm i32 load/store front end: bounds check, word splitting for unaligned
// accesses, read-modify-write for partial stores, sign/zero extension of load data.
module wasm_mem_access_unit #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  wasm_mem_access_unit_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] WR0  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [33:0] LIMIT = 34'(4 * DEPTH);

  logic [2:0]            state_q, state_d;
  logic                  store_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            lane_q;
  logic [29:0]           word_q;
  logic [31:0]           wdata_q;
  logic                  trap_q;
  logic                  span_q;
  logic [DATA_WIDTH-1:0] w0_q;
  logic [DATA_WIDTH-1:0] w1_q;

  logic        accept;
  logic [32:0] ea;
  logic [3:0]  nbytes_in;
  logic [33:0] end_addr;
  logic        trap_in;
  logic        span_in;

  // Accept-time decode on the live request fields.
  always_comb begin
    accept    = bus.req_valid & bus.req_ready;
    ea        = {1'b0, bus.req_base} + {1'b0, bus.req_offset};
    nbytes_in = 4'd1 << bus.req_size;
    end_addr  = {1'b0, ea} + {30'd0, nbytes_in};
    trap_in   = ea[32] | (end_addr > LIMIT) | (bus.req_size == 2'd3);
    span_in   = ({2'b00, ea[1:0]} + nbytes_in) > 4'd4;
  end

  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] wdata_sh;
  logic [63:0] merged;
  logic [31:0] rd_sh;
  logic [31:0] load_val;

  // Store merge over the {w1, w0} window and load extraction from the same window.
  always_comb begin
    unique case (size_q)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      default: byte_mask = 8'h0F;
    endcase
    byte_mask = byte_mask << lane_q;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    wdata_sh = {32'd0, wdata_q} << {lane_q, 3'b000};
    merged   = ({w1_q, w0_q} & ~bit_mask) | (wdata_sh & bit_mask);

    rd_sh = 32'({w1_q, w0_q} >> {lane_q, 3'b000});
    unique case (size_q)
      2'd0:    load_val = {{24{signed_q & rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    load_val = {{16{signed_q & rd_sh[15]}}, rd_sh[15:0]};
      default: load_val = rd_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = trap_in ? DONE : RD0;
      RD0: begin
        if (bus.mem_rd_data_vld) begin
          if (span_q)       state_d = RD1;
          else if (store_q) state_d = WR0;
          else              state_d = DONE;
        end
      end
      RD1:     if (bus.mem_rd_data_vld) state_d = store_q ? WR0 : DONE;
      WR0:     state_d = span_q ? WR1 : DONE;
      WR1:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset silences the memory port at once.
  always_comb begin
    bus.req_ready   = (state_q == IDLE) & ~rst;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = '0;
    bus.resp_trap   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wr_data = '0;
    case (state_q)
      RD0: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {2'b00, word_q};
      end
      RD1: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {2'b00, word_q + 30'd1};
      end
      WR0: begin
        bus.mem_we      = 1'b1;
        bus.mem_addr    = {2'b00, word_q};
        bus.mem_wr_data = merged[31:0];
      end
      WR1: begin
        bus.mem_we      = 1'b1;
        bus.mem_addr    = {2'b00, word_q + 30'd1};
        bus.mem_wr_data = merged[63:32];
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_trap  = trap_q;
        bus.resp_rdata = (store_q | trap_q) ? 32'd0 : load_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      lane_q   <= 2'd0;
      word_q   <= '0;
      wdata_q  <= '0;
      trap_q   <= 1'b0;
      span_q   <= 1'b0;
      w0_q     <= '0;
      w1_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= bus.req_store;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        lane_q   <= ea[1:0];
        word_q   <= ea[31:2];
        wdata_q  <= bus.req_wdata;
        trap_q   <= trap_in;
        span_q   <= span_in;
      end
      if (state_q == RD0 && bus.mem_rd_data_vld) w0_q <= bus.mem_rd_data;
      if (state_q == RD1 && bus.mem_rd_data_vld) w1_q <= bus.mem_rd_data;
    end
  end

endmodule

// File: tb/tb_wasm_mem_access_unit.sv
// Scoreboard bench for wasm_mem_access_unit: directed requests push expectations, a monitor
// pops and checks data, trap, latency and memory-port activity on every response.
module tb_wasm_mem_access_unit;

  logic clk;
  logic rst;

  wasm_mem_access_unit_if #(.DATA_WIDTH(32)) bus ();

  wasm_mem_access_unit #(
    .DEPTH      (1024),
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        trap;
    int          lat;
    int          nre;
    int          nwe;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  logic [31:0] mem [0:1023];
  logic        preload;
  logic        stall_arm;
  int          stall_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_rd_data     = bus.mem_re ? mem[bus.mem_addr[9:0]] : 32'h0;
  assign bus.mem_rd_data_vld = (stall_cnt == 0);

  // Memory model, cycle counter and read-valid stall generator.
  initial begin
    cyc       = 0;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (preload) begin
        mem[0]    <= 32'h44332211;
        mem[1]    <= 32'h88776655;
        mem[1023] <= 32'hCAFEF00D;
      end else if (bus.mem_we) begin
        mem[bus.mem_addr[9:0]] <= bus.mem_wr_data;
      end
      if (stall_arm) stall_cnt <= 3;
      else if (bus.mem_re && stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: per-transaction memory-port activity and response checking.
  int   n_re;
  int   n_we;
  logic bad_seen;
  initial begin
    exp_t e;
    n_re     = 0;
    n_we     = 0;
    bad_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_re     = 0;
        n_we     = 0;
        bad_seen = 1'b0;
      end else begin
        if (bus.mem_re) n_re++;
        if (bus.mem_we) n_we++;
        if (bus.mem_re && bus.mem_we) bad_seen = 1'b1;
        if (!bus.mem_re && !bus.mem_we && (bus.mem_addr != 0 || bus.mem_wr_data != 0))
          bad_seen = 1'b1;
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got resp_valid=1, expected no response");
          end else begin
            e = sb.pop_front();
            chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({e.name, "_trap"}, {31'd0, bus.resp_trap}, {31'd0, e.trap});
            chk({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            chk({e.name, "_num_re"}, 32'(n_re), 32'(e.nre));
            chk({e.name, "_num_we"}, 32'(n_we), 32'(e.nwe));
            chk({e.name, "_bus_rules"}, {31'd0, bad_seen}, 32'd0);
          end
          n_re     = 0;
          n_we     = 0;
          bad_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wd;
  endtask

  task automatic wait_ready(input string name, output logic ok);
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    ok = bus.req_ready;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_ready_timeout: got req_ready=0, expected 1", name);
    end
  endtask

  task automatic issue(input string name, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_trap,
                       input int lat, input int nre, input int nwe);
    exp_t e;
    logic ok;
    wait_ready(name, ok);
    if (!ok) return;
    drive(st, sz, sg, base, off, wd);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e.rdata = exp_rd;
    e.trap  = exp_trap;
    e.lat   = lat;
    e.nre   = nre;
    e.nwe   = nwe;
    e.acc   = cyc;
    e.name  = name;
    sb.push_back(e);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_resp_timeout: got no resp_valid, expected one", name);
      sb.delete();
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  initial begin
    logic ok;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    preload     = 1'b1;
    stall_arm   = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("reset_mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    preload = 1'b0;
    rst     = 1'b0;
    #1;
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

    //     name          st sz sg base          off    wdata         rdata         tr lat re we
    issue("ld_w_ea0",    0, 2, 0, 32'd0,        32'd0, 32'd0,        32'h44332211, 0, 2, 1, 0);
    issue("ld_b_s_ea7",  0, 0, 1, 32'd4,        32'd3, 32'd0,        32'hFFFFFF88, 0, 2, 1, 0);
    issue("ld_b_u_ea7",  0, 0, 0, 32'd4,        32'd3, 32'd0,        32'h00000088, 0, 2, 1, 0);
    issue("ld_h_ea3",    0, 1, 0, 32'd3,        32'd0, 32'd0,        32'h00005544, 0, 3, 2, 0);
    issue("ld_h_s_ea6",  0, 1, 1, 32'd6,        32'd0, 32'd0,        32'hFFFF8877, 0, 2, 1, 0);
    issue("ld_w_ea4092", 0, 2, 0, 32'd4092,     32'd0, 32'd0,        32'hCAFEF00D, 0, 2, 1, 0);
    issue("ld_b_ea4095", 0, 0, 0, 32'd4095,     32'd0, 32'd0,        32'h000000CA, 0, 2, 1, 0);
    issue("trap_bound",  0, 2, 0, 32'd4094,     32'd0, 32'd0,        32'h00000000, 1, 1, 0, 0);
    issue("trap_carry",  0, 0, 0, 32'hFFFFFFFF, 32'd2, 32'd0,        32'h00000000, 1, 1, 0, 0);
    issue("trap_size3",  0, 3, 0, 32'd0,        32'd0, 32'd0,        32'h00000000, 1, 1, 0, 0);

    issue("st_w_ea2",    1, 2, 0, 32'd2,        32'd0, 32'hDEADBEEF, 32'h00000000, 0, 5, 2, 2);
    issue("ld_after_w0", 0, 2, 0, 32'd0,        32'd0, 32'd0,        32'hBEEF2211, 0, 2, 1, 0);
    issue("ld_after_w1", 0, 2, 0, 32'd4,        32'd0, 32'd0,        32'h8877DEAD, 0, 2, 1, 0);
    issue("st_h_ea0",    1, 1, 0, 32'd0,        32'd0, 32'h1234CAFE, 32'h00000000, 0, 3, 1, 1);
    issue("st_b_ea5",    1, 0, 0, 32'd1,        32'd4, 32'h000000AB, 32'h00000000, 0, 3, 1, 1);
    issue("ld_st_h0",    0, 2, 0, 32'd0,        32'd0, 32'd0,        32'hBEEFCAFE, 0, 2, 1, 0);
    issue("ld_st_b1",    0, 2, 0, 32'd4,        32'd0, 32'd0,        32'h8877ABAD, 0, 2, 1, 0);
    issue("ld_h_ea5",    0, 1, 1, 32'd5,        32'd0, 32'd0,        32'h000077AB, 0, 2, 1, 0);
    issue("st_b_ea4095", 1, 0, 0, 32'd4095,     32'd0, 32'h00000011, 32'h00000000, 0, 3, 1, 1);
    issue("st_trap",     1, 2, 0, 32'd4094,     32'd0, 32'h55555555, 32'h00000000, 1, 1, 0, 0);
    issue("ld_w_top",    0, 2, 0, 32'd4092,     32'd0, 32'd0,        32'h11FEF00D, 0, 2, 1, 0);

    // Read-valid held low for three RD0 cycles.
    do_preload();
    @(negedge clk);
    stall_arm = 1'b1;
    @(negedge clk);
    stall_arm = 1'b0;
    issue("ld_stall",    0, 2, 0, 32'd0,        32'd0, 32'd0,        32'h44332211, 0, 5, 4, 0);

    // Reset asserted during WR0 of a spanning store.
    wait_ready("rst_store", ok);
    if (ok) begin
      drive(1'b1, 2'd2, 1'b0, 32'd2, 32'd0, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.mem_we; i++) @(negedge clk);
      chk("rst_reached_wr0", {31'd0, bus.mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);
    end
    issue("ld_rst_w1",   0, 2, 0, 32'd4,        32'd0, 32'd0,        32'h88776655, 0, 2, 1, 0);
    issue("ld_rst_w0",   0, 2, 0, 32'd0,        32'd0, 32'd0,        32'h44332211, 0, 2, 1, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
